// File: rtl/int_to_fp32_pipe.sv
// int_to_fp32_pipe: 3-stage integer to IEEE-754 binary32 converter.
// Define ITF_RMODE_EN to honour rnd_mode; otherwise RNE is hard-wired.
module int_to_fp32_pipe #(
    parameter int INT_WIDTH = 32,
    parameter int LZC_W     = $clog2(INT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_data,
    input  logic                 in_signed,
    input  logic [1:0]           rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_inexact,
    output logic                 out_zero
);

    localparam int W = INT_WIDTH;

    logic w_en;
    logic w_sign;
    logic [W:0] w_abs_full;
    logic [LZC_W-1:0] w_lz;
    logic [W+23:0] w_ext;
    logic [22:0] w_mant;
    logic w_g, w_r, w_s, w_rne, w_up;
    logic [23:0] w_sum;
    logic [7:0] w_exp;

    logic r1_v, r1_sign, r1_zero;
    logic [W-1:0] r1_abs;
    logic r2_v, r2_sign, r2_zero;
    logic [W-1:0] r2_norm;
    logic [7:0] r2_exp;
    logic r3_v;
    logic [31:0] r_out_data;
    logic r_out_inexact, r_out_zero;

`ifdef ITF_RMODE_EN
    logic [1:0] r1_rm, r2_rm;
    logic w_unused;
    assign w_unused = ^{w_abs_full[W], w_ext[W+23]};
`else
    logic w_unused;
    assign w_unused = ^{rnd_mode, w_abs_full[W], w_ext[W+23]};
`endif

    assign w_en        = !r3_v | out_ready;
    assign in_ready    = w_en;
    assign out_valid   = r3_v;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;
    assign out_zero    = r_out_zero;

    // Magnitude at W+1 bits so the most-negative input stays representable
    assign w_sign     = in_signed & in_data[W-1];
    assign w_abs_full = w_sign ? (-{in_data[W-1], in_data})
                               : {1'b0, in_data};

    // Stage 1 register: sign, magnitude, zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v    <= 1'b0;
            r1_sign <= 1'b0;
            r1_zero <= 1'b0;
            r1_abs  <= '0;
`ifdef ITF_RMODE_EN
            r1_rm   <= 2'b00;
`endif
        end else if (w_en) begin
            r1_v <= in_valid;
            if (in_valid) begin
                r1_sign <= w_sign;
                r1_zero <= (in_data == '0);
                r1_abs  <= w_abs_full[W-1:0];
`ifdef ITF_RMODE_EN
                r1_rm   <= rnd_mode;
`endif
            end
        end
    end

    // Leading-zero count: the highest set bit wins
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < W; i++) begin
            if (r1_abs[i]) w_lz = LZC_W'(W - 1 - i);
        end
    end

    // Stage 2 register: normalised magnitude and unbiased exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_v    <= 1'b0;
            r2_sign <= 1'b0;
            r2_zero <= 1'b0;
            r2_norm <= '0;
            r2_exp  <= '0;
`ifdef ITF_RMODE_EN
            r2_rm   <= 2'b00;
`endif
        end else if (w_en) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sign <= r1_sign;
                r2_zero <= r1_zero;
                r2_norm <= r1_abs << w_lz;
                r2_exp  <= 8'(W - 1) - 8'(w_lz);
`ifdef ITF_RMODE_EN
                r2_rm   <= r1_rm;
`endif
            end
        end
    end

    // Mantissa extraction, G/R/S and rounding
    always_comb begin
        w_ext  = {r2_norm, 24'b0};
        w_mant = w_ext[W+22 -: 23];
        w_g    = w_ext[W-1];
        w_r    = w_ext[W-2];
        w_s    = |w_ext[W-3:0];
        w_rne  = w_g & (w_r | w_s | w_mant[0]);
        w_up   = w_rne;
`ifdef ITF_RMODE_EN
        unique case (r2_rm)
            2'b00: w_up = w_rne;
            2'b01: w_up = 1'b0;
            2'b10: w_up = !r2_sign & (w_g | w_r | w_s);
            2'b11: w_up = r2_sign & (w_g | w_r | w_s);
        endcase
`endif
        w_sum = {1'b0, w_mant} + 24'(w_up);
        w_exp = 8'd127 + r2_exp + {7'b0, w_sum[23]};
    end

    // Stage 3 register: packed result held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_v          <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
            r_out_zero    <= 1'b0;
        end else if (w_en) begin
            r3_v <= r2_v;
            if (r2_v) begin
                if (r2_zero) begin
                    r_out_data    <= '0;
                    r_out_inexact <= 1'b0;
                    r_out_zero    <= 1'b1;
                end else begin
                    r_out_data    <= {r2_sign, w_exp, w_sum[22:0]};
                    r_out_inexact <= w_g | w_r | w_s;
                    r_out_zero    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp32_pipe.sv
// tb_int_to_fp32_pipe: directed checks of the int_to_fp32_pipe converter.
// Expected fp32 encodings are hand-computed; rounding-mode cases follow ITF_RMODE_EN.
module tb_int_to_fp32_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic [1:0]  rnd_mode = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        out_zero;

    int_to_fp32_pipe #(.INT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed),
        .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inexact(out_inexact),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] rq_d[$], eq_d[$];
    logic        rq_x[$], eq_x[$];
    logic        rq_z[$], eq_z[$];
    int          rq_c[$], aq[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Collect every result that transfers downstream
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rq_d.push_back(out_data);
            rq_x.push_back(out_inexact);
            rq_z.push_back(out_zero);
            rq_c.push_back(cyc);
        end
    end

    task automatic send(logic [31:0] d, logic s, logic [1:0] rm,
                        logic [31:0] ed, logic ex, logic ez);
        int k;
        eq_d.push_back(ed);
        eq_x.push_back(ex);
        eq_z.push_back(ez);
        in_data   = d;
        in_signed = s;
        rnd_mode  = rm;
        in_valid  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (k >= 100) check("accept_timeout", in_ready, 1);
        aq.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(string tag, logic timing);
        int k;
        int n;
        k = 0;
        while (rq_d.size() < eq_d.size() && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, rq_d.size(), eq_d.size());
        n = (rq_d.size() < eq_d.size()) ? rq_d.size() : eq_d.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), rq_d[i], eq_d[i]);
            check($sformatf("%s_inx%0d", tag, i), rq_x[i], eq_x[i]);
            check($sformatf("%s_zero%0d", tag, i), rq_z[i], eq_z[i]);
        end
        if (timing && n > 0 && aq.size() > 0) begin
            check({tag, "_latency"}, rq_c[0] - aq[0], 3);
            check({tag, "_consec"}, rq_c[n-1] - rq_c[0], n - 1);
        end
        rq_d.delete(); rq_x.delete(); rq_z.delete(); rq_c.delete();
        eq_d.delete(); eq_x.delete(); eq_z.delete(); aq.delete();
    endtask

    logic [31:0] e_rtz, e_pinf, e_ninf;

    initial begin
`ifdef ITF_RMODE_EN
        e_rtz  = 32'h4F7FFFFF;
        e_pinf = 32'h4B800001;
        e_ninf = 32'hCB800001;
`else
        e_rtz  = 32'h4F800000;
        e_pinf = 32'h4B800000;
        e_ninf = 32'hCB800000;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_inx", out_inexact, 0);
        check("rst_zero", out_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);

        // Back-to-back stream
        send(32'h01000001, 0, 2'b00, 32'h4B800000, 1, 0);
        send(32'h01000003, 0, 2'b00, 32'h4B800002, 1, 0);
        send(32'hFFFFFFFF, 1, 2'b00, 32'hBF800000, 0, 0);
        send(32'h80000000, 1, 2'b00, 32'hCF000000, 0, 0);
        send(32'h80000000, 0, 2'b00, 32'h4F000000, 0, 0);
        send(32'hFFFFFFFF, 0, 2'b00, 32'h4F800000, 1, 0);
        send(32'hFFFFFFFF, 0, 2'b01, e_rtz, 1, 0);
        send(32'h00000000, 1, 2'b00, 32'h00000000, 0, 1);
        send(32'h00000001, 0, 2'b00, 32'h3F800000, 0, 0);
        send(32'h00000005, 1, 2'b00, 32'h40A00000, 0, 0);
        send(32'h01000002, 0, 2'b00, 32'h4B800001, 0, 0);
        send(32'h01000001, 0, 2'b10, e_pinf, 1, 0);
        send(32'hFEFFFFFF, 1, 2'b11, e_ninf, 1, 0);
        drain("strm", 1);

        // Backpressure with the pipe full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(32'd3, 0, 2'b00, 32'h40400000, 0, 0);
                send(32'd7, 0, 2'b00, 32'h40E00000, 0, 0);
                send(32'd10, 0, 2'b00, 32'h41200000, 0, 0);
                send(32'hFFFFFFFE, 1, 2'b00, 32'hC0000000, 0, 0);
            end
        join_none
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            check($sformatf("bp_ready%0d", i), in_ready, 0);
            check($sformatf("bp_hold%0d", i), out_data, 32'h40400000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain("bp", 0);

        // Reset with two transactions in flight
        @(posedge clk);
        #1;
        send(32'd100, 0, 2'b00, 32'h42C80000, 0, 0);
        send(32'd200, 0, 2'b00, 32'h43480000, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_inx", out_inexact, 0);
        eq_d.delete(); eq_x.delete(); eq_z.delete(); aq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stale_out", rq_d.size(), 0);
        send(32'd100, 0, 2'b00, 32'h42C80000, 0, 0);
        drain("post_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/int_to_fp32_pipe.md
Name: int_to_fp32_pipe

Overview:
- Pipelined, parametrised integer-to-IEEE-754 binary32 converter for the FP datapath front end.
- Features:
  - configurable input width
  - per-transaction signed/unsigned select
  - correct round-to-nearest-even with an inexact flag
  - valid/ready handshake with full backpressure
- Feeds the FP multiplier operand path. 3-stage pipeline, one result per cycle sustained.

Parameters:
- INT_WIDTH, 32, integer input width; legal range 8..64. The fp32 exponent can never overflow in this range.
- LZC_W, $clog2(INT_WIDTH), width of the leading-zero count.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  converter can accept an input this cycle.
- in_data  input  INT_WIDTH  integer operand.
- in_signed  input  1  1 = two's-complement operand, 0 = unsigned operand.
- rnd_mode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  fp32 result.
- out_inexact  output  1  discarded bits were nonzero.
- out_zero  output  1  result is +0.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, out_data=0, out_inexact=0, out_zero=0; in_ready=1 once out of reset.
- Pipeline enable:
  - en = !out_valid | out_ready.
  - in_ready = en, combinational.
  - Transfer happens on in_valid & in_ready.
  - When en=0, all stages hold their contents, including bubbles; bubbles are not compressed.
- Latency: exactly 3 enabled cycles from accept to out_valid. Throughput is 1/cycle when out_ready=1.
- S1 (stage 1):
  - sign = in_signed & in_data[MSB].
  - abs = sign ? -in_data : in_data, computed at INT_WIDTH+1 bits so the most-negative value yields magnitude 2^(INT_WIDTH-1) without overflow.
  - zero = (in_data == 0).
  - rnd_mode is registered with the transaction.
- S2 (stage 2):
  - lz = leading-zero count of abs.
  - norm = abs << lz.
  - exp_unb = INT_WIDTH-1-lz.
- S3 (stage 3):
  - The mantissa is the 23 bits below the leading 1. Guard bit, round bit, and sticky bit (OR of all remaining lower bits) are formed; for INT_WIDTH ≤ 24, G=R=S=0.
  - Round-up per mode:
    - RNE: G & (R|S|lsb)
    - RTZ: 0
    - +inf: !sign & (G|R|S)
    - -inf: sign & (G|R|S)
  - Mantissa carry-out: mantissa field = 0, exponent + 1.
  - Biased exponent = 127 + exp_unb + carry.
  - inexact = G|R|S.
  - Zero input → out_data = 0x00000000 (never -0), out_zero=1, inexact=0.
- out_data/out_inexact/out_zero update only when en=1 and hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain in the same cycle are legal and lose no data.
- Reset mid-operation: all in-flight transactions are discarded; no partial output appears after reset release.
- Never produces Inf, NaN, or denormals; no overflow or underflow outputs.

Optional Feature:
- Macro ITF_RMODE_EN.
- Defined: rnd_mode is honoured as described above.
- Undefined: rnd_mode is ignored and RNE is hard-wired; the port remains present, and the directed-rounding logic is not synthesised.

Test Plan:
- INT_WIDTH=32, unsigned, RNE: 0x01000001 → 0x4B800000, inexact=1 (tie to even down). 0x01000003 → 0x4B800002, inexact=1 (tie to even up).
- Signed 0xFFFFFFFF → 0xBF800000, inexact=0. Signed 0x80000000 → 0xCF000000. Unsigned 0x80000000 → 0x4F000000.
- Unsigned 0xFFFFFFFF, RNE → 0x4F800000, inexact=1 (carry bumps exponent). Same input with RTZ (ITF_RMODE_EN defined) → 0x4F7FFFFF. Same input with macro undefined and rnd_mode=01 → 0x4F800000.
- in_data=0, signed → out_data=0x00000000, out_zero=1. Back-to-back stream of 8 values with out_ready=1 → 8 results on 8 consecutive cycles, first 3 cycles after first accept.
- Backpressure: out_ready held 0 for 5 cycles with the pipe full → in_ready=0, out_data stable, no loss or duplication. Release → remaining results in order.
- Assert rst_n low with 2 transactions in flight → outputs zero immediately. After release, no stale out_valid; next input converts with 3-cycle latency.
